// File: rtl/mnist_nn_pkg.sv
// Shared constants and register-map types for the MNIST fixed-point output port.
package mnist_nn_pkg;

    localparam int unsigned DEFAULT_WIDTH = 16;
    localparam int unsigned DEFAULT_DEPTH = 8;

    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 32;

    // Avalon-MM word addresses
    localparam logic [ADDR_W-1:0] ADDR_DATA   = 2'd0;
    localparam logic [ADDR_W-1:0] ADDR_STATUS = 2'd1;
    localparam logic [ADDR_W-1:0] ADDR_CTRL   = 2'd2;
    localparam logic [ADDR_W-1:0] ADDR_DEPTH  = 2'd3;

    // Status register bit positions
    localparam int unsigned STAT_EMPTY_BIT = 0;
    localparam int unsigned STAT_FULL_BIT  = 1;
    localparam int unsigned STAT_OVF_BIT   = 2;
    localparam int unsigned STAT_COUNT_LSB = 8;
    localparam int unsigned STAT_COUNT_W   = 4;

    // Control register bit positions
    localparam int unsigned CTRL_FLUSH_BIT   = 0;
    localparam int unsigned CTRL_CLR_OVF_BIT = 1;

    // Status word layout; field order matches the bit indices above
    typedef struct packed {
        logic [19:0]             rsvd_hi;
        logic [STAT_COUNT_W-1:0] count;
        logic [4:0]              rsvd_lo;
        logic                    overflow;
        logic                    full;
        logic                    empty;
    } status_t;

    // Assemble a status word with reserved fields zeroed
    function automatic status_t pack_status(
        input logic [STAT_COUNT_W-1:0] count,
        input logic                    overflow,
        input logic                    full,
        input logic                    empty
    );
        status_t s;
        s          = '0;
        s.count    = count;
        s.overflow = overflow;
        s.full     = full;
        s.empty    = empty;
        return s;
    endfunction

endpackage

// File: rtl/mnist_nn_sync_fifo.sv
// Single-clock FIFO with flush; head word is visible while not empty, 0 otherwise.
module mnist_nn_sync_fifo
    import mnist_nn_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH),
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_en_c;
    logic             pop_en_c;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign count = count_q;
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

    // Qualify requests: flush overrides both, a full FIFO only accepts when popping
    always_comb begin
        pop_en_c  = pop & ~empty & ~flush;
        push_en_c = push & ~flush & (~full | pop_en_c);
    end

    // Pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_en_c) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop_en_c) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push_en_c, pop_en_c})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while the slot is unoccupied
    always_ff @(posedge clk) begin
        if (push_en_c) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/mnist_nn_fixedpoint_out.sv
// Avalon-MM slave that queues fixed-point samples for a streaming hardware consumer.
module mnist_nn_fixedpoint_out
    import mnist_nn_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic              wr_c;
    logic              push_c;
    logic              ctrl_wr_c;
    logic              flush_c;
    logic              clr_ovf_c;
    logic              pop_c;
    logic              ovf_event_c;
    logic              full;
    logic              empty;
    logic [CW-1:0]     count;
    logic [WIDTH-1:0]  head;
    logic              overflow_q, overflow_d;
    logic [DATA_W-1:0] readdata_q, readdata_d;
    logic              unused_wdata;

    // Upper write-data bits are intentionally ignored
    assign unused_wdata = ^writedata;

    // Bus decode and stream handshake
    always_comb begin
        wr_c        = chipselect & ~write_n;
        push_c      = wr_c & (address == ADDR_DATA);
        ctrl_wr_c   = wr_c & (address == ADDR_CTRL);
        flush_c     = ctrl_wr_c & writedata[CTRL_FLUSH_BIT];
        clr_ovf_c   = ctrl_wr_c & writedata[CTRL_CLR_OVF_BIT];
        pop_c       = out_valid & out_ready;
        ovf_event_c = push_c & full & ~pop_c & ~flush_c;
    end

    mnist_nn_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_c),
        .push_data (writedata[WIDTH-1:0]),
        .pop       (pop_c),
        .flush     (flush_c),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .head      (head)
    );

    assign out_valid = ~empty;
    assign out_data  = head;

    // Sticky overflow: a new event beats a simultaneous clear
    always_comb begin
        overflow_d = overflow_q;
        if (ovf_event_c) begin
            overflow_d = 1'b1;
        end else if (clr_ovf_c) begin
            overflow_d = 1'b0;
        end
    end

    // Read mux, sampled every cycle regardless of chipselect
    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA:   readdata_d = DATA_W'(head);
            ADDR_STATUS: readdata_d = DATA_W'(pack_status(STAT_COUNT_W'(count),
                                                          overflow_q, full, empty));
            ADDR_CTRL:   readdata_d = '0;
            default:     readdata_d = DATA_W'(DEPTH);
        endcase
    end

    // Control/status registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q <= 1'b0;
            readdata_q <= '0;
        end else begin
            overflow_q <= overflow_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;

endmodule

// File: doc/mnist_nn_fixedpoint_out.md
MNIST_NN_FIXEDPOINT_OUT -- requirements
Module: mnist_nn_fixedpoint_out

Interface
REQ-001 SHALL have parameter WIDTH, default 16: fixed-point sample width.
REQ-002 SHALL have parameter DEPTH, default 8: FIFO depth in words, a power of 2.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port address, input, 2 bits: Avalon-MM slave word address.
REQ-006 SHALL have port chipselect, input, 1 bit: slave select.
REQ-007 SHALL have port write_n, input, 1 bit: active-low write strobe, qualified by chipselect.
REQ-008 SHALL have port writedata, input, 32 bits: write data.
REQ-009 SHALL have port readdata, output, 32 bits: registered read data.
REQ-010 SHALL have port out_data, output, WIDTH bits: head-of-FIFO sample to the hardware consumer.
REQ-011 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-012 SHALL have port out_ready, input, 1 bit: consumer accepts out_data.

Function
REQ-013 A write is defined as chipselect=1 and write_n=0.
REQ-014 Write to address 0 SHALL push writedata[WIDTH-1:0] into the FIFO; upper bits are ignored.
REQ-015 Write to address 2 SHALL act as control: bit0=flush (empties the FIFO); bit1=clear overflow.
REQ-016 Writes to addresses 1 and 3 SHALL have no effect.
REQ-017 readdata SHALL update every cycle, independent of chipselect, with the address-selected value zero-extended; latency is 1 cycle.
REQ-018 Read map: addr0 = head word (0 when empty); addr1 = status {count at [11:8], overflow [2], full [1], empty [0]}; addr2 = 0; addr3 = DEPTH.
REQ-019 out_valid SHALL equal not-empty; out_data SHALL equal the head word, or 0 when empty.
REQ-020 A pop occurs when out_valid=1 and out_ready=1; the head advances on that clock edge.
REQ-021 A push into an empty FIFO SHALL give out_valid=1 on the cycle after the write edge; there is no bypass.
REQ-022 Push and pop in the same cycle SHALL both execute; count is unchanged; this applies even when full.
REQ-023 A push when full with no simultaneous pop SHALL be discarded and SHALL set sticky overflow.
REQ-024 Flush coincident with push or pop: flush wins; the FIFO ends empty; the push is discarded; overflow is not set.
REQ-025 Clear-overflow coincident with a new overflow event: set wins.
REQ-026 count SHALL range 0..DEPTH; read and write pointers SHALL wrap modulo DEPTH.

Reset
REQ-027 Reset SHALL clear: readdata=0, count=0, pointers=0, overflow=0, out_valid=0, out_data=0.
REQ-028 Reset asserted mid-transfer SHALL discard all FIFO contents; FIFO RAM contents need not be cleared.
REQ-029 After reset release, the first write SHALL be accepted on the first clock edge.

Structure
REQ-030 Package mnist_nn_pkg SHALL hold: address constants (ADDR_DATA=0, ADDR_STATUS=1, ADDR_CTRL=2, ADDR_DEPTH=3), status and control bit indices, and the default WIDTH.
REQ-031 The FIFO SHALL be sub-module mnist_nn_sync_fifo (push, pop, flush, full, empty, count, head); the Avalon decode and readdata register live in the top.

Verification
REQ-032 Reset, then write 0x1234 to addr0 with out_ready=0 -> out_valid=1 on the next cycle; out_data=0x1234; addr1 read gives 0x00000100.
REQ-033 Write 9 words 1..9 with out_ready=0 -> full=1, count=8, overflow=1; pop all -> out_data order 1..8; word 9 is never output.
REQ-034 Full FIFO, out_ready=1, and a write of 0xAAAA in the same cycle -> count stays 8; overflow stays 0; 0xAAAA is output last.
REQ-035 FIFO holds 3 words; write ctrl=0x1 in the same cycle as a push -> next cycle empty=1, out_valid=0, count=0.
REQ-036 overflow=1, then ctrl=0x2 written in the same cycle as a full-FIFO push -> overflow remains 1; ctrl=0x2 alone -> overflow becomes 0.
REQ-037 Assert reset_n=0 asynchronously while holding 5 words -> out_valid and readdata drop to 0 immediately; after release, addr1 reads 0x00000001.
